// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the F/D, D/E and E/M registers and the hazard unit.
// Holds the nop encoding, the default reset PC, the Tnew tag type and the D->E payload.
package pipe_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned TNEW_W = 2;
   localparam int unsigned CNT_W  = 32;

   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_3000;
   localparam logic [XLEN-1:0] PC_LINK_OFS      = 32'd8;

   // Cycles until a result is available, counted from E entry
   typedef enum logic [TNEW_W-1:0] {
      TNEW_0 = 2'd0,
      TNEW_1 = 2'd1,
      TNEW_2 = 2'd2
   } tnew_t;

   // Contents of the D->E pipeline register
   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc8;
      logic [XLEN-1:0] rs_data;
      logic [XLEN-1:0] rt_data;
      logic [XLEN-1:0] ext_imm;
      tnew_t           tnew;
      logic            valid;
   } de_payload_t;

   // jal link value, wraps modulo 2^32
   function automatic logic [XLEN-1:0] link_pc(input logic [XLEN-1:0] pc);
      return XLEN'(pc + PC_LINK_OFS);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// 32-bit saturating event counter with increment enable.
// Ports: clk, reset (async, active-high), inc (count one event), count (registered value).
module sat_counter
   import pipe_pkg::*;
#(
   parameter int unsigned W = CNT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Stop at all-ones instead of wrapping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/de_pipe_reg.sv
// Decode-to-Execute pipeline register with hold (en=0) and bubble insertion (clr=1).
// Ports: clk, reset (async, active-high), en, clr, D_* stage inputs
//        (instr, pc, rs_data, rt_data, ext_imm, tnew), E_* registered outputs
//        (instr, pc, pc8, rs_data, rt_data, ext_imm, tnew, valid).
// Optional DE_PIPE_STAT_EN: adds bubble_cnt / hold_cnt saturating statistics counters.
module de_pipe_reg
   import pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        clr,
   input  logic [31:0] D_instr,
   input  logic [31:0] D_pc,
   input  logic [31:0] D_rs_data,
   input  logic [31:0] D_rt_data,
   input  logic [31:0] D_ext_imm,
   input  logic [1:0]  D_tnew,
   output logic [31:0] E_instr,
   output logic [31:0] E_pc,
   output logic [31:0] E_pc8,
   output logic [31:0] E_rs_data,
   output logic [31:0] E_rt_data,
   output logic [31:0] E_ext_imm,
   output logic [1:0]  E_tnew,
   output logic        E_valid
`ifdef DE_PIPE_STAT_EN
   ,
   output logic [31:0] bubble_cnt,
   output logic [31:0] hold_cnt
`endif
);

   de_payload_t e_q;

   // Priority: reset > clr > hold > capture. A bubble keeps PC tracking continuous.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_q.instr   <= NOP_INSTR;
         e_q.pc      <= RESET_PC;
         e_q.pc8     <= link_pc(RESET_PC);
         e_q.rs_data <= '0;
         e_q.rt_data <= '0;
         e_q.ext_imm <= '0;
         e_q.tnew    <= TNEW_0;
         e_q.valid   <= 1'b0;
      end else if (clr) begin
         e_q.instr   <= NOP_INSTR;
         e_q.pc      <= D_pc;
         e_q.pc8     <= link_pc(D_pc);
         e_q.rs_data <= '0;
         e_q.rt_data <= '0;
         e_q.ext_imm <= '0;
         e_q.tnew    <= TNEW_0;
         e_q.valid   <= 1'b0;
      end else if (en) begin
         e_q.instr   <= D_instr;
         e_q.pc      <= D_pc;
         e_q.pc8     <= link_pc(D_pc);
         e_q.rs_data <= D_rs_data;
         e_q.rt_data <= D_rt_data;
         e_q.ext_imm <= D_ext_imm;
         e_q.tnew    <= tnew_t'(D_tnew);
         e_q.valid   <= 1'b1;
      end
   end

   assign E_instr   = e_q.instr;
   assign E_pc      = e_q.pc;
   assign E_pc8     = e_q.pc8;
   assign E_rs_data = e_q.rs_data;
   assign E_rt_data = e_q.rt_data;
   assign E_ext_imm = e_q.ext_imm;
   assign E_tnew    = e_q.tnew;
   assign E_valid   = e_q.valid;

`ifdef DE_PIPE_STAT_EN
   logic bubble_ev;
   logic hold_ev;

   // Bubble wins over hold, so an edge counts in at most one counter
   assign bubble_ev = clr;
   assign hold_ev   = ~clr & ~en;

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (bubble_ev),
      .count (bubble_cnt)
   );

   sat_counter #(.W(CNT_W)) u_hold_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (hold_ev),
      .count (hold_cnt)
   );
`endif

endmodule

// File: tb/tb_de_pipe_reg.sv
// Self-checking bench for de_pipe_reg: directed steps plus randomized traffic
// compared against a behavioural model of the D->E register.
module tb_de_pipe_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic        clr;
   logic [31:0] D_instr, D_pc, D_rs_data, D_rt_data, D_ext_imm;
   logic [1:0]  D_tnew;
   logic [31:0] E_instr, E_pc, E_pc8, E_rs_data, E_rt_data, E_ext_imm;
   logic [1:0]  E_tnew;
   logic        E_valid;
`ifdef DE_PIPE_STAT_EN
   logic [31:0] bubble_cnt, hold_cnt;
`endif

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [31:0] m_instr, m_pc, m_pc8, m_rs, m_rt, m_imm;
   logic [1:0]  m_tnew;
   logic        m_valid;
   longint      m_bub, m_hold;

   always #5 clk = ~clk;

   de_pipe_reg dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .clr       (clr),
      .D_instr   (D_instr),
      .D_pc      (D_pc),
      .D_rs_data (D_rs_data),
      .D_rt_data (D_rt_data),
      .D_ext_imm (D_ext_imm),
      .D_tnew    (D_tnew),
      .E_instr   (E_instr),
      .E_pc      (E_pc),
      .E_pc8     (E_pc8),
      .E_rs_data (E_rs_data),
      .E_rt_data (E_rt_data),
      .E_ext_imm (E_ext_imm),
      .E_tnew    (E_tnew),
      .E_valid   (E_valid)
`ifdef DE_PIPE_STAT_EN
      ,
      .bubble_cnt (bubble_cnt),
      .hold_cnt   (hold_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_instr = 32'h0; m_pc = 32'h3000; m_pc8 = 32'h3008;
      m_rs = 32'h0; m_rt = 32'h0; m_imm = 32'h0; m_tnew = 2'd0; m_valid = 1'b0;
      m_bub = 0; m_hold = 0;
   endtask

   // One clock edge of the specified behaviour, using the inputs presented at the edge
   task automatic model_edge();
      if (clr) begin
         m_instr = 32'h0; m_rs = 32'h0; m_rt = 32'h0; m_imm = 32'h0; m_tnew = 2'd0;
         m_valid = 1'b0;
         m_pc = D_pc; m_pc8 = D_pc + 32'd8;
         if (m_bub < 64'hFFFF_FFFF) m_bub++;
      end else if (en) begin
         m_instr = D_instr; m_rs = D_rs_data; m_rt = D_rt_data; m_imm = D_ext_imm;
         m_tnew = D_tnew; m_valid = 1'b1;
         m_pc = D_pc; m_pc8 = D_pc + 32'd8;
      end else begin
         if (m_hold < 64'hFFFF_FFFF) m_hold++;
      end
   endtask

   task automatic check_all(input string ctx);
      chk({ctx, ".E_instr"},   E_instr,   m_instr);
      chk({ctx, ".E_pc"},      E_pc,      m_pc);
      chk({ctx, ".E_pc8"},     E_pc8,     m_pc8);
      chk({ctx, ".E_rs_data"}, E_rs_data, m_rs);
      chk({ctx, ".E_rt_data"}, E_rt_data, m_rt);
      chk({ctx, ".E_ext_imm"}, E_ext_imm, m_imm);
      chk({ctx, ".E_tnew"},    32'(E_tnew),  32'(m_tnew));
      chk({ctx, ".E_valid"},   32'(E_valid), 32'(m_valid));
`ifdef DE_PIPE_STAT_EN
      chk({ctx, ".bubble_cnt"}, bubble_cnt, 32'(m_bub));
      chk({ctx, ".hold_cnt"},   hold_cnt,   32'(m_hold));
`endif
   endtask

   task automatic drive(input logic e, input logic c, input logic [31:0] instr,
                        input logic [31:0] pc, input logic [1:0] tnew);
      en = e; clr = c; D_instr = instr; D_pc = pc; D_tnew = tnew;
      D_rs_data = $urandom; D_rt_data = $urandom; D_ext_imm = $urandom;
   endtask

   task automatic step(input string ctx);
      @(posedge clk);
      model_edge();
      #1;
      check_all(ctx);
   endtask

   initial begin
      logic [31:0] hold_snap;
      reset = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
      model_reset();
      #2;
      check_all("reset_init");
      reset = 1'b0;

      // Capture a lui
      drive(1'b1, 1'b0, 32'h3C01_1234, 32'h0000_3004, 2'd1);
      step("capture_lui");
      chk("capture_lui.pc8_const", E_pc8, 32'h0000_300C);
      chk("capture_lui.valid_const", 32'(E_valid), 32'd1);

      // Bubble with en=0 in the same cycle
      drive(1'b0, 1'b1, $urandom, 32'h0000_3010, 2'd2);
      step("bubble");
      chk("bubble.instr_const", E_instr, 32'h0);
      chk("bubble.pc8_const", E_pc8, 32'h0000_3018);
      chk("bubble.valid_const", 32'(E_valid), 32'd0);

      // Valid lw, then three holds while D_* changes
      drive(1'b1, 1'b0, 32'h8C22_0004, 32'h0000_3014, 2'd2);
      step("load_lw");
`ifdef DE_PIPE_STAT_EN
      hold_snap = hold_cnt;
`else
      hold_snap = 32'h0;
`endif
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, $urandom, $urandom, 2'($urandom_range(0, 2)));
         step("hold");
         chk("hold.instr_const", E_instr, 32'h8C22_0004);
         chk("hold.valid_const", 32'(E_valid), 32'd1);
      end
`ifdef DE_PIPE_STAT_EN
      chk("hold.cnt_delta", hold_cnt - hold_snap, 32'd3);
`else
      hold_snap = hold_snap + 32'd0;
`endif

      // PC + 8 wrap-around
      drive(1'b1, 1'b0, $urandom, 32'hFFFF_FFFC, 2'd0);
      step("wrap");
      chk("wrap.pc8_const", E_pc8, 32'h0000_0004);

      // Reset mid-stream while holding a valid instruction
      drive(1'b1, 1'b0, 32'h0123_4567, 32'h0000_4000, 2'd1);
      step("pre_reset_load");
      drive(1'b0, 1'b0, $urandom, $urandom, 2'd1);
      step("pre_reset_hold");
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all("reset_mid");
      #1;
      reset = 1'b0;
      drive(1'b1, 1'b0, 32'h2001_0005, 32'h0000_3000, 2'd1);
      step("post_reset_capture");

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
               $urandom, $urandom, 2'($urandom_range(0, 2)));
         step("random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Safety net so the run always ends
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/de_pipe_reg.md
# de_pipe_reg

Decode-to-Execute pipeline register for the 5-stage MIPS core. It captures the instruction, PC, register-file read data, extended immediate and Tnew hazard tag produced in D. It presents them to the E stage, where the execute control decoder and ALU consume them. It supports hold (enable low) and bubble insertion (clear) for the stall/flush logic, and carries a valid bit so downstream stages can tell real instructions from bubbles.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded into E_pc on reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  1: capture D-stage values; 0: hold current contents
- clr  in  1  1: load a bubble at the next edge (overrides en)
- D_instr  in  32  instruction word from D
- D_pc  in  32  PC of the D instruction
- D_rs_data  in  32  forwarded rs read data
- D_rt_data  in  32  forwarded rt read data
- D_ext_imm  in  32  sign/zero/upper-extended immediate
- D_tnew  in  2  cycles until result available, counted from E entry (lw 2, ALU/lui 1, jal 0, no-write 0)
- E_instr  out  32  registered instruction
- E_pc  out  32  registered PC
- E_pc8  out  32  registered D_pc + 8, the jal link value
- E_rs_data, E_rt_data, E_ext_imm  out  32 each  registered operands
- E_tnew  out  2  registered Tnew
- E_valid  out  1  1 = E holds a real instruction, 0 = bubble

## Operation
- Edge priority: reset > clr > hold (en=0) > capture (en=1).
- Capture: all E_* outputs take the matching D_* values. E_pc8 takes D_pc + 32'd8, computed modulo 2^32 with carry discarded. E_valid is set to 1.
- Bubble (clr=1, regardless of en):
  - E_instr, E_rs_data, E_rt_data, E_ext_imm and E_tnew are set to 0. Instruction 0 is sll $0,$0,0, a nop, so it decodes as a destination-$0, no-write instruction.
  - E_valid is set to 0.
  - E_pc takes D_pc and E_pc8 takes D_pc + 8, so PC tracking stays continuous for debug and exception logic.
- Hold: every register keeps its value, including E_valid. A held bubble stays a bubble.
- All outputs come directly from registers. There is no combinational path from D_* to E_*.

## Timing
- Latency is one cycle from D_* to E_* on capture.
- Reset takes effect immediately, without waiting for a clock edge:
  - E_pc = RESET_PC and E_pc8 = RESET_PC + 8.
  - Every other output is 0, including E_valid.
- Reset asserted mid-operation discards the held contents. The first edge after reset deasserts performs normal capture, bubble or hold according to clr and en.
- clr and en are sampled at the rising edge only. When clr=1 and en=0 in the same cycle, the result is a bubble.
- D-stage inputs must be stable at the edge. Forwarding mux outputs are captured as presented.

## Configuration
- Macro DE_PIPE_STAT_EN.
- When defined, two extra outputs exist: bubble_cnt (32 bits) and hold_cnt (32 bits).
  - bubble_cnt increments on every edge that loads a bubble.
  - hold_cnt increments on every edge with en=0 and clr=0.
  - Both saturate at 32'hFFFF_FFFF and reset asynchronously to 0.
- When undefined, the ports and counter logic are absent. Pipeline behaviour is identical either way.

## Structure
- Shared package pipe_pkg holds:
  - NOP_INSTR = 32'h0000_0000
  - DEFAULT_RESET_PC = 32'h0000_3000
  - the 2-bit Tnew type and its encodings (TNEW_0/1/2)
- The package is shared with the F/D and E/M registers and with the hazard unit.
- One sub-module, sat_counter, is a 32-bit saturating counter with increment enable and asynchronous reset. It is instantiated twice, only under DE_PIPE_STAT_EN.

## Test plan
- Reset: assert reset between edges -> outputs change immediately: E_pc=0x3000, E_pc8=0x3008, every other output 0, including E_valid=0.
- Capture: en=1, clr=0, D_instr=0x3C011234 (lui), D_pc=0x3004, D_tnew=1 -> next cycle E_instr=0x3C011234, E_pc8=0x300C, E_tnew=1, E_valid=1.
- Bubble with conflicting enable: clr=1, en=0, D_pc=0x3010 -> E_instr=0, E_tnew=0, E_valid=0, E_pc=0x3010, E_pc8=0x3018. With DE_PIPE_STAT_EN defined, bubble_cnt increases by 1 and hold_cnt is unchanged.
- Hold: load a valid lw (tnew 2), then three cycles of en=0 while D_* changes -> E_* unchanged and E_valid=1 throughout. With DE_PIPE_STAT_EN defined, hold_cnt=3.
- Wrap-around: capture D_pc=0xFFFF_FFFC -> E_pc8=0x0000_0004.
- Reset mid-stream: reset asserted while holding a valid instruction -> immediate return to reset values. After deassertion, the first capture behaves normally. With DE_PIPE_STAT_EN defined, both counters are 0 after reset.
